adder_rr_scheduler: RTL and testbench

- Shares one `adder` datapath instance among NUM_REQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Per requester: valid/ready handshake for operands, valid/ready handshake for the result.
- Sits between requester logic and the adder. Drives the adder's a/b/valid and captures its c.

---
 rtl/adder_rr_scheduler_if.sv | 55 +++++
 rtl/adder_rr_scheduler.sv | 132 +++++++++++++
 tb/tb_adder_rr_scheduler.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// adder_rr_scheduler_if
//
// Requester-side bundle of the shared-adder scheduler: per-requester operand
// request channel and per-requester result channel with a shared data bus.
//
//   req_valid [NUM_REQ]       requester -> scheduler, operand request
//   req_ready [NUM_REQ]       scheduler -> requester, one-hot accept pulse
//   req_a/b   [NUM_REQ*OP_W]  packed operands, slice i belongs to requester i
//   rsp_valid [NUM_REQ]       scheduler -> requester, one-hot result valid
//   rsp_ready [NUM_REQ]       requester -> scheduler, result acceptance
//   rsp_data  [RES_W]         shared result bus
//   rsp_id    [ID_W]          owner index of rsp_data
//
// slave  : scheduler side
// master : requester side
// ---------------------------------------------------------------------------
interface adder_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int OP_W    = 4,
    parameter int RES_W   = 7
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*OP_W-1:0] req_a;
    logic [NUM_REQ*OP_W-1:0] req_b;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [NUM_REQ-1:0]      rsp_ready;
    logic [RES_W-1:0]        rsp_data;
    logic [ID_W-1:0]         rsp_id;

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_id
    );

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_id
    );
endinterface

// File: rtl/adder_rr_scheduler.sv
// ---------------------------------------------------------------------------
// adder_rr_scheduler
//
// Shares one registered adder among NUM_REQ requesters. Round-robin grant,
// one operation in flight: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   bus        adder_rr_scheduler_if.slave (requester handshakes)
//   add_a/b    operands to the adder
//   add_valid  one-cycle strobe to the adder (ISSUE state)
//   add_c      adder sum, sampled only in CAPTURE
//   busy       high in any state other than IDLE
// ---------------------------------------------------------------------------
module adder_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int OP_W    = 4,
    parameter int RES_W   = 7
) (
    input  logic                clk,
    input  logic                reset,
    adder_rr_scheduler_if.slave bus,
    output logic [OP_W-1:0]     add_a,
    output logic [OP_W-1:0]     add_b,
    output logic                add_valid,
    input  logic [RES_W-1:0]    add_c,
    output logic                busy
);
    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("adder_rr_scheduler: NUM_REQ must be in 2..16");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant;
    logic               add_valid_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [RES_W-1:0]   rsp_data_q;
    logic [ID_W-1:0]    rsp_id_q;

    logic               arb_found;
    logic [ID_W-1:0]    arb_idx;
    logic [ID_W:0]      cand;
    logic               accept;
    logic [NUM_REQ-1:0] req_ready_c;

    // Rotating priority search starting at rr_ptr. cand is one bit wider so
    // rr_ptr + i never overflows before the modulo fold.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!arb_found && bus.req_valid[cand[ID_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign accept      = (state == IDLE) && arb_found && !reset;
    assign req_ready_c = accept ? (NUM_REQ'(1) << arb_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            add_a       <= '0;
            add_b       <= '0;
            add_valid_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        add_a       <= bus.req_a[arb_idx*OP_W +: OP_W];
                        add_b       <= bus.req_b[arb_idx*OP_W +: OP_W];
                        grant       <= arb_idx;
                        add_valid_q <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    add_valid_q <= 1'b0;
                    state       <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_data_q  <= add_c;
                    rsp_id_q    <= grant;
                    rsp_valid_q <= NUM_REQ'(1) << grant;
                    state       <= RESP;
                end
                RESP: begin
                    // Only the owner's rsp_ready completes the response.
                    if (bus.rsp_ready[grant]) begin
                        rsp_valid_q <= '0;
                        rr_ptr      <= (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are masked by reset so nothing leaks out during the reset
    // cycle itself, before the registers have been cleared.
    assign add_valid     = add_valid_q & ~reset;
    assign busy          = (state != IDLE) & ~reset;
    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q & {NUM_REQ{~reset}};
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
module tb_adder_rr_scheduler;
    localparam int NUM_REQ = 4;
    localparam int OP_W    = 4;
    localparam int RES_W   = 7;
    localparam int ID_W    = 2;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [RES_W-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [OP_W-1:0]  add_a;
    logic [OP_W-1:0]  add_b;
    logic             add_valid;
    logic [RES_W-1:0] add_c;
    logic             busy;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    adder_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .OP_W(OP_W), .RES_W(RES_W)) bus ();

    adder_rr_scheduler #(.NUM_REQ(NUM_REQ), .OP_W(OP_W), .RES_W(RES_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_valid (add_valid),
        .add_c     (add_c),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Registered adder with a non-zero reset value on c.
    always_ff @(posedge clk) begin
        if (reset) add_c <= 7'h5A;
        else if (add_valid) add_c <= RES_W'(add_a) + RES_W'(add_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int r, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        bus.req_a[r*OP_W +: OP_W] = a;
        bus.req_b[r*OP_W +: OP_W] = b;
    endtask

    task automatic push_exp(input int r, input logic [RES_W-1:0] s);
        exp_t e;
        e.id   = ID_W'(r);
        e.data = s;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = '1;
        bus.req_a = '1;
        bus.req_b = '1;
        repeat (3) tick();
        #1;
        checks++;
        if (bus.req_ready !== '0) begin
            errors++; $display("FAIL reset_req_ready got %b exp 0000", bus.req_ready);
        end
        checks++;
        if ({bus.rsp_valid, add_valid, busy} !== '0) begin
            errors++; $display("FAIL reset_strobes got %b exp 0", {bus.rsp_valid, add_valid, busy});
        end
        checks++;
        if ({add_a, add_b, bus.rsp_data, bus.rsp_id} !== '0) begin
            errors++; $display("FAIL reset_regs got %h exp 0", {add_a, add_b, bus.rsp_data, bus.rsp_id});
        end
        bus.req_valid = '0;
        reset = 1'b0;
        tick();
        #1;
        checks++;
        if ({busy, bus.rsp_valid, bus.req_ready} !== '0) begin
            errors++; $display("FAIL reset_idle got %b exp 0", {busy, bus.rsp_valid, bus.req_ready});
        end
    endtask

    task automatic test_single(input int r, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                               input logic [RES_W-1:0] sum);
        exp_t e;
        int n;
        int av;
        logic [NUM_REQ-1:0] oh;
        logic [NUM_REQ-1:0] ev;
        oh = NUM_REQ'(1) << r;
        set_op(r, a, b);
        bus.req_valid = oh;
        #1;
        checks++;
        if (bus.req_ready !== oh) begin
            errors++; $display("FAIL single_req_ready got %b exp %b", bus.req_ready, oh);
        end
        push_exp(r, sum);
        tick();
        bus.req_valid = '0;
        #1;
        checks++;
        if ({add_valid, add_a, add_b, busy, bus.req_ready} !== {1'b1, a, b, 1'b1, 4'b0000}) begin
            errors++; $display("FAIL single_issue got %h exp %h",
                {add_valid, add_a, add_b, busy, bus.req_ready}, {1'b1, a, b, 1'b1, 4'b0000});
        end
        av = 1;
        n = 1;
        while (bus.rsp_valid === '0 && n < 20) begin
            tick(); #1; n++;
            if (add_valid === 1'b1) av++;
        end
        checks++;
        if (n !== 3) begin
            errors++; $display("FAIL single_latency got %0d exp 3", n);
        end
        checks++;
        if (av !== 1) begin
            errors++; $display("FAIL single_add_valid_cycles got %0d exp 1", av);
        end
        if (sb.size() == 0) begin
            checks++; errors++; $display("FAIL single_sb_empty got rsp exp none");
        end else begin
            e = sb.pop_front();
            ev = NUM_REQ'(1) << e.id;
            checks++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {ev, e.id, e.data}) begin
                errors++; $display("FAIL single_rsp got v=%b id=%0d d=%0d exp v=%b id=%0d d=%0d",
                    bus.rsp_valid, bus.rsp_id, bus.rsp_data, ev, e.id, e.data);
            end
        end
        tick();
        #1;
        checks++;
        if ({busy, bus.rsp_valid} !== '0) begin
            errors++; $display("FAIL single_return_idle got %b exp 0", {busy, bus.rsp_valid});
        end
    endtask

    task automatic test_fairness();
        logic [OP_W-1:0]  fa [4] = '{4'd1, 4'd6, 4'd11, 4'd14};
        logic [OP_W-1:0]  fb [4] = '{4'd2, 4'd5, 4'd3, 4'd15};
        logic [RES_W-1:0] fs [4] = '{7'd3, 7'd11, 7'd14, 7'd29};
        int eg [5] = '{0, 1, 2, 3, 0};
        int acc = 0;
        int nrsp = 0;
        int last = 0;
        exp_t e;
        logic [NUM_REQ-1:0] ev;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.rsp_ready = '1;
        for (int r = 0; r < NUM_REQ; r++) set_op(r, fa[r], fb[r]);
        for (int cyc = 0; cyc < 60 && nrsp < 5; cyc++) begin
            bus.req_valid = (acc < 5) ? '1 : '0;
            #1;
            if (bus.req_ready !== '0) begin
                if (acc >= 5) begin
                    checks++; errors++; $display("FAIL fair_extra_grant got %b exp 0000", bus.req_ready);
                end else begin
                    ev = NUM_REQ'(1) << eg[acc];
                    checks++;
                    if (bus.req_ready !== ev) begin
                        errors++; $display("FAIL fair_grant got %b exp %b", bus.req_ready, ev);
                    end
                    if (acc > 0) begin
                        checks++;
                        if (cyc - last !== 4) begin
                            errors++; $display("FAIL fair_spacing got %0d exp 4", cyc - last);
                        end
                    end
                    push_exp(eg[acc], fs[eg[acc]]);
                    last = cyc;
                    acc++;
                end
            end
            if (bus.rsp_valid !== '0) begin
                if (sb.size() == 0) begin
                    checks++; errors++; $display("FAIL fair_sb_empty got v=%b exp none", bus.rsp_valid);
                end else begin
                    e = sb.pop_front();
                    ev = NUM_REQ'(1) << e.id;
                    checks++;
                    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {ev, e.id, e.data}) begin
                        errors++; $display("FAIL fair_rsp got v=%b id=%0d d=%0d exp v=%b id=%0d d=%0d",
                            bus.rsp_valid, bus.rsp_id, bus.rsp_data, ev, e.id, e.data);
                    end
                end
                nrsp++;
            end
            tick();
        end
        bus.req_valid = '0;
        checks++;
        if (acc != 5 || nrsp != 5) begin
            errors++; $display("FAIL fair_count got acc=%0d rsp=%0d exp 5/5", acc, nrsp);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int n;
        logic [NUM_REQ-1:0] ev;
        set_op(1, 4'd9, 4'd4);
        set_op(3, 4'd7, 4'd8);
        bus.rsp_ready = 4'b1101;
        bus.req_valid = 4'b0010;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_req_ready got %b exp 0010", bus.req_ready);
        end
        push_exp(1, 7'd13);
        tick();
        bus.req_valid = '0;
        #1;
        n = 0;
        while (bus.rsp_valid === '0 && n < 20) begin tick(); #1; n++; end
        if (sb.size() == 0) begin
            checks++; errors++; $display("FAIL bp_sb_empty got rsp exp none");
        end else begin
            e = sb.pop_front();
            ev = NUM_REQ'(1) << e.id;
            checks++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {ev, e.id, e.data}) begin
                errors++; $display("FAIL bp_rsp got v=%b id=%0d d=%0d exp v=%b id=%0d d=%0d",
                    bus.rsp_valid, bus.rsp_id, bus.rsp_data, ev, e.id, e.data);
            end
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            bus.req_valid = 4'b1000;
            #1;
            checks++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, busy, bus.req_ready} !==
                {4'b0010, 2'd1, 7'd13, 1'b1, 4'b0000}) begin
                errors++; $display("FAIL bp_hold got v=%b id=%0d d=%0d busy=%b rdy=%b exp v=0010 id=1 d=13 busy=1 rdy=0000",
                    bus.rsp_valid, bus.rsp_id, bus.rsp_data, busy, bus.req_ready);
            end
        end
        tick();
        bus.rsp_ready = '1;
        #1;
        checks++;
        if ({bus.rsp_valid, bus.req_ready} !== {4'b0010, 4'b0000}) begin
            errors++; $display("FAIL bp_release_cycle got %b exp 00100000", {bus.rsp_valid, bus.req_ready});
        end
        tick();
        #1;
        checks++;
        if ({busy, bus.rsp_valid, bus.req_ready} !== {1'b0, 4'b0000, 4'b1000}) begin
            errors++; $display("FAIL bp_next_accept got %b exp 000001000", {busy, bus.rsp_valid, bus.req_ready});
        end
        push_exp(3, 7'd15);
        tick();
        bus.req_valid = '0;
        #1;
        n = 0;
        while (bus.rsp_valid === '0 && n < 20) begin tick(); #1; n++; end
        if (sb.size() == 0) begin
            checks++; errors++; $display("FAIL bp3_sb_empty got rsp exp none");
        end else begin
            e = sb.pop_front();
            ev = NUM_REQ'(1) << e.id;
            checks++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {ev, e.id, e.data}) begin
                errors++; $display("FAIL bp3_rsp got v=%b id=%0d d=%0d exp v=%b id=%0d d=%0d",
                    bus.rsp_valid, bus.rsp_id, bus.rsp_data, ev, e.id, e.data);
            end
        end
        tick();
    endtask

    task automatic test_wrap();
        exp_t e;
        int n;
        int eg [2] = '{0, 3};
        logic [RES_W-1:0] es [2] = '{7'd2, 7'd10};
        int acc = 0;
        int nrsp = 0;
        logic [NUM_REQ-1:0] ev;
        bus.rsp_ready = '1;
        set_op(3, 4'd2, 4'd2);
        bus.req_valid = 4'b1000;
        #1;
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            errors++; $display("FAIL wrap_first_ready got %b exp 1000", bus.req_ready);
        end
        push_exp(3, 7'd4);
        tick();
        bus.req_valid = '0;
        #1;
        n = 0;
        while (bus.rsp_valid === '0 && n < 20) begin tick(); #1; n++; end
        if (sb.size() == 0) begin
            checks++; errors++; $display("FAIL wrap_sb_empty got rsp exp none");
        end else begin
            e = sb.pop_front();
            ev = NUM_REQ'(1) << e.id;
            checks++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {ev, e.id, e.data}) begin
                errors++; $display("FAIL wrap_first_rsp got v=%b id=%0d d=%0d exp v=%b id=%0d d=%0d",
                    bus.rsp_valid, bus.rsp_id, bus.rsp_data, ev, e.id, e.data);
            end
        end
        tick();
        set_op(0, 4'd1, 4'd1);
        set_op(3, 4'd5, 4'd5);
        for (int cyc = 0; cyc < 40 && nrsp < 2; cyc++) begin
            bus.req_valid = {(acc < 2), 2'b00, (acc < 1)};
            #1;
            if (bus.req_ready !== '0) begin
                if (acc >= 2) begin
                    checks++; errors++; $display("FAIL wrap_extra_grant got %b exp 0000", bus.req_ready);
                end else begin
                    ev = NUM_REQ'(1) << eg[acc];
                    checks++;
                    if (bus.req_ready !== ev) begin
                        errors++; $display("FAIL wrap_grant got %b exp %b", bus.req_ready, ev);
                    end
                    push_exp(eg[acc], es[acc]);
                    acc++;
                end
            end
            if (bus.rsp_valid !== '0) begin
                if (sb.size() == 0) begin
                    checks++; errors++; $display("FAIL wrap_sb_empty2 got v=%b exp none", bus.rsp_valid);
                end else begin
                    e = sb.pop_front();
                    ev = NUM_REQ'(1) << e.id;
                    checks++;
                    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {ev, e.id, e.data}) begin
                        errors++; $display("FAIL wrap_rsp got v=%b id=%0d d=%0d exp v=%b id=%0d d=%0d",
                            bus.rsp_valid, bus.rsp_id, bus.rsp_data, ev, e.id, e.data);
                    end
                end
                nrsp++;
            end
            tick();
        end
        bus.req_valid = '0;
        checks++;
        if (acc != 2 || nrsp != 2) begin
            errors++; $display("FAIL wrap_count got acc=%0d rsp=%0d exp 2/2", acc, nrsp);
        end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        bus.rsp_ready = '1;
        set_op(2, 4'd5, 4'd6);
        // Reset while the adder strobe is up.
        bus.req_valid = 4'b0100;
        #1;
        tick();
        bus.req_valid = '0;
        reset = 1'b1;
        #1;
        checks++;
        if ({add_valid, busy, bus.req_ready} !== '0) begin
            errors++; $display("FAIL rstmid_issue_gate got %b exp 0", {add_valid, busy, bus.req_ready});
        end
        tick();
        reset = 1'b0;
        #1;
        // Reset during CAPTURE.
        bus.req_valid = 4'b0100;
        #1;
        tick();
        bus.req_valid = '0;
        tick();
        #1;
        checks++;
        if ({busy, add_valid, bus.rsp_valid} !== {1'b1, 1'b0, 4'b0000}) begin
            errors++; $display("FAIL rstmid_capture_state got %b exp 100000", {busy, add_valid, bus.rsp_valid});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, add_valid, bus.rsp_valid} !== '0) begin
            errors++; $display("FAIL rstmid_after got %b exp 0", {busy, add_valid, bus.rsp_valid});
        end
        repeat (10) begin
            tick(); #1;
            if (bus.rsp_valid !== '0 || busy !== 1'b0) stale++;
        end
        checks++;
        if (stale !== 0) begin
            errors++; $display("FAIL rstmid_stale got %0d exp 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_single(2, 4'd3, 4'd4, 7'd7);
        test_single(0, 4'd15, 4'd15, 7'd30);
        test_fairness();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
